operand_loader: RTL and testbench
=================================

# operand_loader

Front-end stage for the seven-bit adder. Turns four raw, bouncing pushbuttons and a 4-bit switch bank into two registered 7-bit operands, `a` and `b`. It synchronises and debounces the buttons, then sequences the four nibble loads through a state machine. It flags when both operands are complete so the adder output can be shown.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples needed to accept a button level change. Range 1..65535.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pb`  in  4  raw pushbuttons, active-high:
  - [0] loads a[3:0]
  - [1] loads a[6:4]
  - [2] loads b[3:0]
  - [3] loads b[6:4]
- `sw`  in  4  raw switch value. High-nibble loads take sw[2:0].
- `a`  out  7  operand A, registered.
- `b`  out  7  operand B, registered.
- `ops_valid`  out  1  level. High while both operands are complete and unchanged since completion.
- `err`  out  1  one-cycle pulse on an out-of-sequence press.
- `expect`  out  2  index of the button currently expected (LED hint).

## Operation
- **Synchroniser:** each `pb` bit and `sw` pass through two flip-flops.
- **Debouncer, per button:**
  - 16-bit counter plus a debounced level `db[i]`.
  - If sync ≠ `db[i]`, the counter increments; otherwise it clears.
  - When the counter reaches `DEBOUNCE_CYCLES`, `db[i]` takes the sync value and the counter clears.
  - A rising edge of `db[i]` produces a one-cycle press pulse `p[i]`.
  - Releases produce no pulse.
- **FSM states:**
  - WAIT_ALO, `expect`=0
  - WAIT_AHI, `expect`=1
  - WAIT_BLO, `expect`=2
  - WAIT_BHI, `expect`=3
  - READY, `expect`=0
- **Transitions:**
  - In WAIT_x, `p[expect]` loads that field from synced `sw` and advances to the next state. WAIT_BHI advances to READY.
  - In READY, `p[0]` loads a[3:0] and goes to WAIT_AHI. `ops_valid` drops on that same edge.
  - In READY, `p[1..3]` are out-of-sequence.
- **Out-of-sequence press:** any `p[i]` with i ≠ `expect` in the current state.
  - Effect: `err`=1 for one cycle; no field change; no state change.
- **Simultaneous pulses:** the expected pulse is accepted. `err` also pulses if any other pulse is present in the same cycle.
- **Field widths:**
  - Low-nibble loads take sw[3:0] into bits [3:0].
  - High loads take sw[2:0] into bits [6:4]; sw[3] is ignored.
  - Unloaded bits keep their previous value.
- **Reset:**
  - Outputs: `a`=0, `b`=0, `ops_valid`=0, `err`=0, `expect`=0.
  - Internal: state WAIT_ALO, all `db`=0, counters=0, synchronisers=0.
  - Reset mid-sequence discards partial loads.
  - A button held through reset release is treated as a fresh press once debounced.

## Timing
- Bounce-free press: `pb[i]` first sampled high at edge E0. Field register and state update at edge E0+`DEBOUNCE_CYCLES`+2.
  - 2 synchroniser edges, `DEBOUNCE_CYCLES`−1 further count edges, 1 edge to `db`, 1 edge to register.
- `sw` must be stable from 2 cycles before that update edge. It is sampled from the synchroniser output on the update edge.
- Glitch rule: a bounce shorter than `DEBOUNCE_CYCLES` synchronised cycles clears the counter and produces no pulse.
- `ops_valid` rises on the same edge that loads b[6:4].
- `err` is high exactly one cycle per offending edge.
- One press pulse per debounced rising edge, regardless of hold time.

## Configuration
- Macro: `OPERAND_LOADER_FREE_ORDER_EN`.
- **Defined:**
  - Any button loads its field in any state.
  - A 4-bit loaded mask sets per field. When all four bits are set, `ops_valid` rises and the mask clears.
  - Any press while `ops_valid`=1 loads its field, drops `ops_valid`, and sets only that mask bit.
  - `err` is tied to 0.
  - `expect` shows the lowest unloaded field index, or 0 when complete.
- **Undefined:** strict sequenced FSM as described above.

## Test plan
- Reset, then clean presses pb0..pb3 with sw=5, 3, 9, 6:
  - a=0x35, b=0x69.
  - `ops_valid` rises on the pb3 load edge; `err` never pulses.
- Each press lands DEBOUNCE_CYCLES+2 edges after its first high sample (18 at default).
- pb0 bouncing high/low every 3 cycles for 40 cycles, then held, sw=0xF:
  - exactly one load; a[3:0]=0xF; `expect`=1.
- In WAIT_ALO, press pb2:
  - `err` one-cycle pulse; a, b unchanged; `expect` stays 0.
- In READY (a=0x35, b=0x69), press pb0 with sw=0xA:
  - a=0x3A; `ops_valid` falls on that edge; `expect`=1.
- Assert `rst_n`=0 asynchronously in WAIT_BHI:
  - a=0, b=0, `ops_valid`=0, `expect`=0 immediately, without waiting for a clock edge.
- With `OPERAND_LOADER_FREE_ORDER_EN` defined, press order pb3, pb1, pb2, pb0 with sw=7, 2, 4, 1:
  - a=0x21, b=0x74; `ops_valid` rises on the pb0 load edge.

Source files
------------

// File: rtl/operand_loader.sv
// Operand front end for the seven-bit adder: synchronises and debounces four pushbuttons and
// sequences nibble loads into operands a and b. Define OPERAND_LOADER_FREE_ORDER_EN for any-order loading.
module operand_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] pb,
    input  logic [3:0] sw,
    output logic [6:0] a,
    output logic [6:0] b,
    output logic       ops_valid,
    output logic       err,
    output logic [1:0] expect_idx
);

    localparam logic [15:0] DB_LIMIT = 16'(DEBOUNCE_CYCLES);

    logic [3:0]  pb_s1, pb_s2, sw_s1, sw_s2;
    logic [15:0] cnt [4];
    logic [3:0]  db, db_q, p;
    logic [3:0]  ld;
    logic        err_set;
    logic        ops_valid_next;

    // Two-flop synchronisers on every raw input bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pb_s1 <= '0;
            pb_s2 <= '0;
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            pb_s1 <= pb;
            pb_s2 <= pb_s1;
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            db   <= '0;
            db_q <= '0;
        end else begin
            db_q <= db;
            for (int i = 0; i < 4; i++) begin
                if (pb_s2[i] != db[i]) begin
                    if (cnt[i] + 16'd1 == DB_LIMIT) begin
                        db[i]  <= pb_s2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 16'd1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign p = db & ~db_q;

`ifdef OPERAND_LOADER_FREE_ORDER_EN
    logic [3:0] mask, mask_next, mask_new;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mask <= '0;
        else        mask <= mask_next;
    end

    // A press after completion starts a fresh set containing only that field
    always_comb begin
        mask_new       = ops_valid ? p : (mask | p);
        mask_next      = mask;
        ops_valid_next = ops_valid;
        ld             = p;
        err_set        = 1'b0;
        if (|p) begin
            if (mask_new == 4'hF) begin
                ops_valid_next = 1'b1;
                mask_next      = '0;
            end else begin
                ops_valid_next = 1'b0;
                mask_next      = mask_new;
            end
        end
    end

    always_comb begin
        expect_idx = 2'd0;
        if (!ops_valid) begin
            if (!mask[0])      expect_idx = 2'd0;
            else if (!mask[1]) expect_idx = 2'd1;
            else if (!mask[2]) expect_idx = 2'd2;
            else               expect_idx = 2'd3;
        end
    end
`else
    typedef enum logic [2:0] {WAIT_ALO, WAIT_AHI, WAIT_BLO, WAIT_BHI, READY} state_t;
    state_t     state, state_next;
    logic [3:0] sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_ALO;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (p[expect_idx]) begin
            case (state)
                WAIT_ALO: state_next = WAIT_AHI;
                WAIT_AHI: state_next = WAIT_BLO;
                WAIT_BLO: state_next = WAIT_BHI;
                WAIT_BHI: state_next = READY;
                READY:    state_next = WAIT_AHI;
                default:  state_next = WAIT_ALO;
            endcase
        end
    end

    // READY expects button 0, which restarts the sequence at a[3:0]
    always_comb begin
        case (state)
            WAIT_AHI: expect_idx = 2'd1;
            WAIT_BLO: expect_idx = 2'd2;
            WAIT_BHI: expect_idx = 2'd3;
            default:  expect_idx = 2'd0;
        endcase
        sel            = 4'b0001 << expect_idx;
        ld             = p & sel;
        err_set        = |(p & ~sel);
        ops_valid_next = (state_next == READY);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a         <= '0;
            b         <= '0;
            ops_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (ld[0]) a[3:0] <= sw_s2;
            if (ld[1]) a[6:4] <= sw_s2[2:0];
            if (ld[2]) b[3:0] <= sw_s2;
            if (ld[3]) b[6:4] <= sw_s2[2:0];
            ops_valid <= ops_valid_next;
            err       <= err_set;
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// Directed self-checking bench for operand_loader at the default debounce length; covers the
// free-order build when OPERAND_LOADER_FREE_ORDER_EN is defined.
module tb_operand_loader;

    localparam int DB = 16;

    logic       clk;
    logic       rst_n;
    logic [3:0] pb;
    logic [3:0] sw;
    logic [6:0] a;
    logic [6:0] b;
    logic       ops_valid;
    logic       err;
    logic [1:0] expect_idx;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

    operand_loader #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pb         (pb),
        .sw         (sw),
        .a          (a),
        .b          (b),
        .ops_valid  (ops_valid),
        .err        (err),
        .expect_idx (expect_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles with err high, sampled mid-cycle
    always @(negedge clk) if (err === 1'b1) err_pulses++;

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [3:0] swval);
        sw      = swval;
        pb[idx] = 1'b1;
    endtask

    task automatic releaseButton(input int idx);
        pb[idx] = 1'b0;
        waitEdges(DB + 4);
    endtask

    task automatic pressButton(input int idx, input logic [3:0] swval);
        applyStimulus(idx, swval);
        waitEdges(DB + 3);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        pb    = 4'h0;
        sw    = 4'h0;
        #23;
        checkOutput("reset_a", 16'(a), 16'h00);
        checkOutput("reset_b", 16'(b), 16'h00);
        checkOutput("reset_ops_valid", 16'(ops_valid), 16'h0);
        checkOutput("reset_err", 16'(err), 16'h0);
        checkOutput("reset_expect", 16'(expect_idx), 16'h0);
        rst_n = 1'b1;
        waitEdges(2);

`ifdef OPERAND_LOADER_FREE_ORDER_EN
        pressButton(3, 4'h7);
        checkOutput("free_pb3_b", 16'(b), 16'h70);
        checkOutput("free_pb3_expect", 16'(expect_idx), 16'h0);
        releaseButton(3);
        pressButton(1, 4'h2);
        checkOutput("free_pb1_a", 16'(a), 16'h20);
        checkOutput("free_pb1_valid", 16'(ops_valid), 16'h0);
        releaseButton(1);
        pressButton(2, 4'h4);
        checkOutput("free_pb2_b", 16'(b), 16'h74);
        checkOutput("free_pb2_valid", 16'(ops_valid), 16'h0);
        releaseButton(2);
        applyStimulus(0, 4'h1);
        waitEdges(DB + 2);
        checkOutput("free_pb0_before_valid", 16'(ops_valid), 16'h0);
        waitEdges(1);
        checkOutput("free_pb0_valid", 16'(ops_valid), 16'h1);
        checkOutput("free_final_a", 16'(a), 16'h21);
        checkOutput("free_final_b", 16'(b), 16'h74);
        checkOutput("free_final_expect", 16'(expect_idx), 16'h0);
        releaseButton(0);
        pressButton(2, 4'h5);
        checkOutput("free_reload_b", 16'(b), 16'h75);
        checkOutput("free_reload_valid", 16'(ops_valid), 16'h0);
        releaseButton(2);
        pressButton(0, 4'h3);
        checkOutput("free_reload_a", 16'(a), 16'h23);
        checkOutput("free_reload_expect", 16'(expect_idx), 16'h1);
        releaseButton(0);
        checkOutput("free_err_pulses", 16'(err_pulses), 16'h0);
`else
        // Out-of-sequence press in WAIT_ALO
        pressButton(2, 4'h5);
        releaseButton(2);
        checkOutput("oos_err_pulses", 16'(err_pulses), 16'h1);
        checkOutput("oos_a", 16'(a), 16'h00);
        checkOutput("oos_b", 16'(b), 16'h00);
        checkOutput("oos_expect", 16'(expect_idx), 16'h0);

        // pb0 with exact load latency
        applyStimulus(0, 4'h5);
        waitEdges(DB + 2);
        checkOutput("pb0_before_a", 16'(a), 16'h00);
        waitEdges(1);
        checkOutput("pb0_a", 16'(a), 16'h05);
        checkOutput("pb0_expect", 16'(expect_idx), 16'h1);
        releaseButton(0);

        pressButton(1, 4'h3);
        checkOutput("pb1_a", 16'(a), 16'h35);
        checkOutput("pb1_expect", 16'(expect_idx), 16'h2);
        releaseButton(1);

        pressButton(2, 4'h9);
        checkOutput("pb2_b", 16'(b), 16'h09);
        checkOutput("pb2_expect", 16'(expect_idx), 16'h3);
        releaseButton(2);

        applyStimulus(3, 4'h6);
        waitEdges(DB + 2);
        checkOutput("pb3_before_valid", 16'(ops_valid), 16'h0);
        waitEdges(1);
        checkOutput("pb3_valid", 16'(ops_valid), 16'h1);
        checkOutput("pb3_b", 16'(b), 16'h69);
        checkOutput("pb3_expect", 16'(expect_idx), 16'h0);
        releaseButton(3);
        checkOutput("seq_err_pulses", 16'(err_pulses), 16'h1);

        // Out-of-sequence press in READY
        pressButton(1, 4'h7);
        releaseButton(1);
        checkOutput("ready_oos_err_pulses", 16'(err_pulses), 16'h2);
        checkOutput("ready_oos_a", 16'(a), 16'h35);
        checkOutput("ready_oos_valid", 16'(ops_valid), 16'h1);

        // Restart from READY with pb0
        applyStimulus(0, 4'hA);
        waitEdges(DB + 2);
        checkOutput("restart_before_valid", 16'(ops_valid), 16'h1);
        waitEdges(1);
        checkOutput("restart_a", 16'(a), 16'h3A);
        checkOutput("restart_valid", 16'(ops_valid), 16'h0);
        checkOutput("restart_expect", 16'(expect_idx), 16'h1);
        releaseButton(0);

        pressButton(1, 4'hB);
        checkOutput("sw3_ignored_a", 16'(a), 16'h3A);
        releaseButton(1);
        pressButton(2, 4'h1);
        checkOutput("mid_b", 16'(b), 16'h61);
        checkOutput("mid_expect", 16'(expect_idx), 16'h3);
        releaseButton(2);

        // Asynchronous reset mid-cycle in WAIT_BHI
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_a", 16'(a), 16'h00);
        checkOutput("async_rst_b", 16'(b), 16'h00);
        checkOutput("async_rst_valid", 16'(ops_valid), 16'h0);
        checkOutput("async_rst_expect", 16'(expect_idx), 16'h0);
        waitEdges(2);
        rst_n = 1'b1;
        waitEdges(2);

        // Bouncing pb0, then held
        sw = 4'hF;
        for (int i = 0; i < 40; i++) begin
            pb[0] = ((i / 3) % 2) == 0;
            waitEdges(1);
        end
        checkOutput("bounce_no_load_a", 16'(a), 16'h00);
        pb[0] = 1'b1;
        waitEdges(DB + 10);
        checkOutput("bounce_a", 16'(a), 16'h0F);
        checkOutput("bounce_expect", 16'(expect_idx), 16'h1);
        checkOutput("bounce_err_pulses", 16'(err_pulses), 16'h2);
        releaseButton(0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
